demux_32_deser: RTL and testbench
=================================

Name: demux_32_deser

Overview:
- Serial-to-parallel receiver; the write-side counterpart of the 32:1 bit mux.
- The mux reads bit opts[sel]; this block writes incoming serial bit n into word[n], using an internal 5-bit index counter as the demux select.
- It presents the completed 32-bit word on a valid/ready output port.
- It sits between a serial bit source and any word-wide consumer, and shares the mux's select/bit-index conventions.

Parameters:
- WIDTH, 32, word length in bits. Must be a power of two, 2..32. Index width IDX_W = $clog2(WIDTH) is a derived localparam.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- word_out  output  WIDTH  assembled word; bit n = nth accepted bit (LSB first).
- word_valid  output  1  word_out is complete and stable.
- word_ready  input  1  consumer accepts word_out.
- bit_idx  output  IDX_W  index the next accepted bit will be written to.

Behaviour:
- Reset (rst=1 at posedge) applies the following, overriding all other activity including a mid-word or HOLD state; partial words are discarded:
  - state = S_FILL, bit_idx = 0, word_out = 0, word_valid = 0, bit_ready = 1.
- Bit handshake: a bit is accepted when bit_valid && bit_ready at posedge.
  - Only word_out[bit_idx] is written with bit_in; all other bits hold.
  - bit_idx increments modulo WIDTH.
- S_FILL:
  - bit_ready = 1, word_valid = 0.
  - Accepting a bit at bit_idx = WIDTH-1 moves to S_HOLD, or to S_PARITY when the feature is enabled. bit_idx wraps to 0.
- S_HOLD:
  - bit_ready = 0, word_valid = 1. word_out is stable while word_valid=1 && !word_ready.
  - On word_valid && word_ready at posedge, go to S_FILL and clear word_out to 0. bit_ready rises the next cycle; there is no same-cycle pass-through.
- Latency: word_valid asserts on the cycle after the posedge that accepts bit WIDTH-1.
- Simultaneous events: bit_valid in S_HOLD is ignored, because bit_ready=0; the source must hold the bit.
  - word_ready outside S_HOLD has no effect.
- bit_valid gaps: allowed at any point; counter and contents hold.
- No overflow is possible: back-pressure through bit_ready is the only flow control.
- State encoding: enumerated type from the package; an illegal state recovers to S_FILL with bit_idx = 0.

Optional Feature:
- Macro: DEMUX_DESER_PARITY_EN.
- Defined:
  - An extra output port parity_err (1 bit, reset 0) is present.
  - After bit WIDTH-1 the FSM enters S_PARITY: bit_ready = 1, and the next accepted bit is an even-parity bit over the word.
  - Accepting it moves to S_HOLD and sets parity_err = ^word_out ^ bit_in. parity_err is valid alongside word_valid and clears on the word handshake.
  - The parity bit is not stored in word_out, and bit_idx stays 0 during S_PARITY.
- Undefined:
  - No S_PARITY state and no parity_err port.
  - The FSM goes S_FILL -> S_HOLD directly.

Decomposition:
- Package demux_deser_pkg holds:
  - typedef enum logic [1:0] {S_FILL, S_PARITY, S_HOLD} deser_state_t;
  - localparam DESER_WIDTH = 32;
  - localparam DESER_IDX_W = 5.
- Sub-module decoder_5to32: purely combinational one-hot write-enable decoder.
  - Input: 5-bit select plus an enable; output: 32-bit one-hot.
  - It is the structural inverse of mux_32 and drives the per-bit write enables.

Test Plan:
- Reset, then 32 bits with value (i%3==0) at one bit per cycle, word_ready=0 -> word_valid=1 on the cycle after bit 31; word_out=32'h49249249; bit_ready=0; bit_idx=0.
- Walking one: for i in 0..31 send a word whose only 1 is bit i, handshake each -> word_out === (32'h1<<i), matching the mux sweep.
- Back-pressure: hold word_ready=0 for 10 cycles with bit_valid=1, bit_in=1 -> word_out unchanged, bit_ready=0 throughout. Then word_ready=1 for 1 cycle -> word_valid=0 next cycle, bit_ready=1, word_out=0.
- Gapped input: toggle bit_valid every other cycle with all bits 1 -> word_out=32'hFFFFFFFF after 64 cycles, and bit_idx tracks only accepted bits.
- Reset mid-word: send 17 bits, then rst=1 for 1 cycle -> bit_idx=0, word_out=0, word_valid=0. Then a clean 32-bit word 32'hDEADBEEF is received intact.
- Parity (with DEMUX_DESER_PARITY_EN): word 32'h00000007 with parity bit 1 -> parity_err=0. The same word with parity bit 0 -> parity_err=1. In both cases word_out=32'h7.

Source files
------------

// File: rtl/demux_deser_pkg.sv
// demux_deser_pkg: shared state encoding and sizes for the serial-to-parallel deserializer
package demux_deser_pkg;
  typedef enum logic [1:0] {S_FILL, S_PARITY, S_HOLD} deser_state_t;
  localparam int DESER_WIDTH = 32;
  localparam int DESER_IDX_W = 5;
endpackage

// File: rtl/demux_32_deser_decoder.sv
// decoder_5to32: one-hot write-enable decoder, the structural inverse of mux_32
module decoder_5to32 (
  input  logic [4:0]  sel,
  input  logic        en,
  output logic [31:0] onehot
);
  always_comb onehot = en ? 32'h1 << sel : '0;
endmodule

// File: rtl/demux_32_deser.sv
// demux_32_deser: serial bit stream to WIDTH-bit word on a valid/ready port, LSB first.
// Define DEMUX_DESER_PARITY_EN to add a trailing even-parity bit and the parity_err output.
module demux_32_deser
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef DEMUX_DESER_PARITY_EN
  output logic             parity_err,
`endif
  output logic [IDX_W-1:0] bit_idx
);
`ifdef DEMUX_DESER_PARITY_EN
  localparam deser_state_t FILL_DONE = S_PARITY;
`else
  localparam deser_state_t FILL_DONE = S_HOLD;
`endif
  deser_state_t state, state_n;
  logic legal, accept, fill_acc, handshake;
  logic [31:0] dec;
  logic [WIDTH-1:0] we;
`ifdef DEMUX_DESER_PARITY_EN
  assign bit_ready = state == S_FILL || state == S_PARITY;
  assign legal = state == S_FILL || state == S_PARITY || state == S_HOLD;
`else
  assign bit_ready = state == S_FILL;
  assign legal = state == S_FILL || state == S_HOLD;
`endif
  assign word_valid = state == S_HOLD;
  assign accept = bit_valid && bit_ready;
  assign fill_acc = accept && state == S_FILL;
  assign handshake = word_valid && word_ready;
  decoder_5to32 u_dec (
    .sel(DESER_IDX_W'(bit_idx)),
    .en(fill_acc),
    .onehot(dec)
  );
  assign we = dec[WIDTH-1:0];
  always_comb begin
    state_n = state;
    if (fill_acc && bit_idx == IDX_W'(WIDTH - 1)) state_n = FILL_DONE;
    if (state == S_PARITY && accept) state_n = S_HOLD;
    if (handshake) state_n = S_FILL;
  end
  // An unreachable encoding is treated like reset so the block always recovers cleanly.
  always_ff @(posedge clk) begin
    if (rst || !legal) begin
      state <= S_FILL;
      bit_idx <= '0;
      word_out <= '0;
`ifdef DEMUX_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (fill_acc) begin
        bit_idx <= bit_idx + 1'b1;
        word_out <= (word_out & ~we) | (we & {WIDTH{bit_in}});
      end
      if (handshake) word_out <= '0;
`ifdef DEMUX_DESER_PARITY_EN
      if (state == S_PARITY && accept) parity_err <= ^word_out ^ bit_in;
      if (handshake) parity_err <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_demux_32_deser.sv
// tb_demux_32_deser: directed self-checking bench for demux_32_deser (default and DEMUX_DESER_PARITY_EN builds)
module tb_demux_32_deser;
  logic clk = 0, rst = 0, bit_in = 0, bit_valid = 0, word_ready = 0;
  logic bit_ready, word_valid;
  logic [31:0] word_out;
  logic [4:0] bit_idx;
  int n_cmp = 0, n_err = 0;
`ifdef DEMUX_DESER_PARITY_EN
  logic parity_err;
`endif

  demux_32_deser dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
`ifdef DEMUX_DESER_PARITY_EN
    .parity_err(parity_err),
`endif
    .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1;
    bit_in = b;
    tick();
    bit_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) send_bit(w[i]);
`ifdef DEMUX_DESER_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic handshake();
    word_ready = 1;
    tick();
    word_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    n_cmp++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid got %b want 0", word_valid); end
    n_cmp++; if (bit_ready !== 1'b1) begin n_err++; $display("FAIL reset_bit_ready got %b want 1", bit_ready); end
    n_cmp++; if (word_out !== 32'h0) begin n_err++; $display("FAIL reset_word_out got %h want 0", word_out); end
    n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
  endtask

  task automatic test_pattern();
    for (int i = 0; i < 5; i++) send_bit(i % 3 == 0);
    n_cmp++; if (bit_idx !== 5'd5) begin n_err++; $display("FAIL pattern_mid_idx got %0d want 5", bit_idx); end
    for (int i = 5; i < 32; i++) send_bit(i % 3 == 0);
`ifdef DEMUX_DESER_PARITY_EN
    n_cmp++; if (word_valid !== 1'b0 || bit_ready !== 1'b1 || bit_idx !== 5'd0) begin
      n_err++; $display("FAIL parity_state got wv=%b br=%b idx=%0d want 0 1 0", word_valid, bit_ready, bit_idx);
    end
    send_bit(1'b1);
`endif
    n_cmp++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL pattern_valid got %b want 1", word_valid); end
    n_cmp++; if (word_out !== 32'h49249249) begin n_err++; $display("FAIL pattern_word got %h want 49249249", word_out); end
    n_cmp++; if (bit_ready !== 1'b0) begin n_err++; $display("FAIL pattern_bit_ready got %b want 0", bit_ready); end
    n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL pattern_bit_idx got %0d want 0", bit_idx); end
    handshake();
  endtask

  task automatic test_walking();
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = 32'h1 << i;
      send_word(w);
      n_cmp++; if (word_out !== w || word_valid !== 1'b1) begin
        n_err++; $display("FAIL walking_%0d got %h v=%b want %h v=1", i, word_out, word_valid, w);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    send_word(32'hA5A5A5A5);
    bit_valid = 1;
    bit_in = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (word_out !== 32'hA5A5A5A5 || bit_ready !== 1'b0 || word_valid !== 1'b1) begin
        n_err++; $display("FAIL backpressure_%0d got %h br=%b wv=%b want a5a5a5a5 0 1", c, word_out, bit_ready, word_valid);
      end
    end
    handshake();
    bit_valid = 0;
    n_cmp++; if (word_valid !== 1'b0 || bit_ready !== 1'b1 || word_out !== 32'h0 || bit_idx !== 5'd0) begin
      n_err++; $display("FAIL release got wv=%b br=%b word=%h idx=%0d want 0 1 0 0", word_valid, bit_ready, word_out, bit_idx);
    end
  endtask

  task automatic test_gapped();
    bit_in = 1;
    for (int c = 0; c < 64; c++) begin
      bit_valid = (c % 2 == 0);
      tick();
      if (c == 31) begin
        n_cmp++; if (bit_idx !== 5'd16) begin n_err++; $display("FAIL gapped_idx got %0d want 16", bit_idx); end
      end
    end
    bit_valid = 0;
`ifdef DEMUX_DESER_PARITY_EN
    send_bit(1'b0);
`endif
    n_cmp++; if (word_out !== 32'hFFFFFFFF || word_valid !== 1'b1) begin
      n_err++; $display("FAIL gapped_word got %h v=%b want ffffffff v=1", word_out, word_valid);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) send_bit(1'b1);
    n_cmp++; if (bit_idx !== 5'd17) begin n_err++; $display("FAIL mid_idx got %0d want 17", bit_idx); end
    rst = 1;
    tick();
    rst = 0;
    n_cmp++; if (bit_idx !== 5'd0 || word_out !== 32'h0 || word_valid !== 1'b0 || bit_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset got idx=%0d word=%h wv=%b br=%b want 0 0 0 1", bit_idx, word_out, word_valid, bit_ready);
    end
    send_word(32'hDEADBEEF);
    n_cmp++; if (word_out !== 32'hDEADBEEF || word_valid !== 1'b1) begin
      n_err++; $display("FAIL deadbeef got %h v=%b want deadbeef v=1", word_out, word_valid);
    end
    handshake();
  endtask

`ifdef DEMUX_DESER_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) send_bit(i < 3);
      send_bit(k == 0);
      n_cmp++; if (parity_err !== (k == 1) || word_out !== 32'h7 || word_valid !== 1'b1) begin
        n_err++; $display("FAIL parity_%0d got err=%b word=%h want err=%b word=7", k, parity_err, word_out, k == 1);
      end
      handshake();
      n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL parity_clear_%0d got %b want 0", k, parity_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_walking();
    test_backpressure();
    test_gapped();
    test_reset_mid();
`ifdef DEMUX_DESER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
